calc_op_sequencer: RTL and testbench
====================================

// Module: calc_op_sequencer
// PURPOSE
//  Top-level operation sequencer for the 8-bit four-function calculator. Latches operands and opcode on Go,
//  runs add/sub directly on the shared adder, and runs mul/div on the multi-cycle units via start/done handshakes.
//  Packs the result, flags divide-by-zero and unit timeouts, and holds the result until the next Go.
// PARAMETERS
//  WIDTH    8    operand width; Result is 2*WIDTH
//  TIMEOUT  64   max cycles to wait in any unit-wait state before Error (must be >= 4*WIDTH)
// PORTS
//  Clock     in   1        single clock, all state updates on rising edge
//  Resetn    in   1        asynchronous, active-low reset
//  Go        in   1        request; sampled only in IDLE or DONE/ERR
//  Op        in   2        00 add, 01 sub, 10 mul, 11 div
//  A, B      in   WIDTH    operands, latched on accepted Go
//  OpA, OpB  out  WIDTH    latched operands driven to adder/mul/div units
//  AddSub    out  1        adder mode: 0 add, 1 subtract
//  SumIn     in   WIDTH+1  adder result incl. carry/borrow bit
//  MulStart  out  1        one-cycle start pulse to multiplier
//  MulDone   in   1        multiplier done (level, high while idle/finished)
//  ProdIn    in   2*WIDTH  multiplier product
//  DivStart  out  1        one-cycle start pulse to divider controller
//  DivDone   in   1        divider Done (level; high only in its end state)
//  QuotIn    in   WIDTH    divider quotient
//  RemIn     in   WIDTH    divider remainder
//  Result    out  2*WIDTH  add/sub: sign-extended SumIn; mul: ProdIn; div: {RemIn,QuotIn}
//  Busy      out  1        high from accepted Go until DONE/ERR
//  Valid     out  1        high in DONE; Result stable
//  Error     out  1        high in ERR; code in ErrCode
//  ErrCode   out  2        00 none, 01 divide-by-zero, 10 timeout
// BEHAVIOUR
//  Reset: state IDLE; Result=0, OpA/OpB=0, AddSub=0, MulStart=DivStart=0, Busy=Valid=Error=0, ErrCode=00.
//  States: IDLE, LATCH, ADDS, MSYNC, MSTART, MWLO, MWHI, DSYNC, DSTART, DWLO, DWHI, DONE, ERR.
//  IDLE/DONE/ERR: Go=1 -> LATCH (latch A,B,Op; clear Valid/Error/ErrCode; Busy=1); else hold.
//  LATCH: Op 0x -> ADDS; 10 -> MSYNC; 11 with B==0 -> ERR(01), no DivStart ever issued; 11 else -> DSYNC.
//  ADDS: AddSub=Op[0]; Result captured from SumIn at end of this cycle -> DONE (Go-to-Valid latency 3 clocks).
//  xSYNC: wait for unit Done=1 (unit idle) -> xSTART. Covers unit left mid-operation by our reset.
//  xSTART: Start=1 for exactly one cycle -> xWLO.
//  xWLO: wait for Done=0 (unit acknowledged) -> xWHI.
//  xWHI: wait for Done=1 -> capture result -> DONE.
//  Timeout: counter cleared on entry to each SYNC/WLO/WHI state, increments each cycle there;
//   reaching TIMEOUT-1 without the exit condition -> ERR(10); counter saturates, no wrap.
//  Done and exit condition in same cycle as timeout: exit condition wins.
//  Go while Busy: ignored, not queued. Go held high across DONE: immediately starts another op (re-latches).
//  Op/A/B changes while Busy: no effect; OpA/OpB/AddSub stay at latched values until next accepted Go.
//  Result updates only on capture; holds through DONE/ERR and into next op until next capture (cleared on ERR).
//  Resetn low mid-operation: all outputs to reset values immediately (async), no Start pulse emitted.
//  Arithmetic: sub result = A-B two's complement, Result = {{(WIDTH-1){SumIn[WIDTH]}}, SumIn}.
// STRUCTURE
//  calc_pkg: op_e (OP_ADD, OP_SUB, OP_MUL, OP_DIV), seq_state_e, err_e (ERR_NONE, ERR_DIV0, ERR_TMO).
//  Sub-module calc_timeout_ctr: clear/enable/saturating counter with terminal flag, parameter TIMEOUT.
//  FSM state and output registers in this module; outputs decoded from registered state (Moore),
//   except Result/ErrCode which are registered on capture/error.
// TESTING
//  Add: A=8'h7F,B=8'h01,Op=00 -> Valid 3 clocks after Go, Result=16'h0080, no Start pulses.
//  Sub: A=8'h03,B=8'h05,Op=01 -> AddSub=1 in ADDS, Result=16'hFFFE, Valid=1.
//  Div: A=8'd100,B=8'd7 with divider model (Done drops 1 cycle after Start, rises after 40) ->
//   exactly one DivStart pulse, Result={8'd2,8'd14}, Valid=1, Busy low.
//  Div0: A=8'd5,B=8'd0,Op=11 -> ERR, ErrCode=01, Error=1, DivStart never asserted.
//  Timeout: Op=10, MulDone stuck low -> ERR with ErrCode=10 exactly TIMEOUT cycles after entering MSYNC.
//  Reset mid-div: drop Resetn in DWHI -> all outputs 0 asynchronously; next div waits in DSYNC until DivDone=1, then pulses.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types for the four-function calculator: opcodes, sequencer states and error codes.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LATCH,
        S_ADDS,
        S_MSYNC,
        S_MSTART,
        S_MWLO,
        S_MWHI,
        S_DSYNC,
        S_DSTART,
        S_DWLO,
        S_DWHI,
        S_DONE,
        S_ERR
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_DIV0 = 2'b01,
        ERR_TMO  = 2'b10
    } err_e;

    // States in which the sequencer is waiting on a unit handshake and the timeout runs.
    function automatic logic is_wait_state(input seq_state_e s);
        return (s == S_MSYNC) || (s == S_MWLO) || (s == S_MWHI) ||
               (s == S_DSYNC) || (s == S_DWLO) || (s == S_DWHI);
    endfunction

endpackage

// File: rtl/calc_timeout_ctr.sv
// Saturating wait-cycle counter; expired is high once the count reaches TIMEOUT-1.
module calc_timeout_ctr #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned   CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/calc_op_sequencer.sv
// Operation sequencer for the 8-bit calculator: latches operands on Go, drives the adder directly
// and the multiplier/divider through start/done handshakes, and holds the packed result.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Go,
    input  logic [1:0]         Op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [WIDTH-1:0]   OpA,
    output logic [WIDTH-1:0]   OpB,
    output logic               AddSub,
    input  logic [WIDTH:0]     SumIn,
    output logic               MulStart,
    input  logic               MulDone,
    input  logic [2*WIDTH-1:0] ProdIn,
    output logic               DivStart,
    input  logic               DivDone,
    input  logic [WIDTH-1:0]   QuotIn,
    input  logic [WIDTH-1:0]   RemIn,
    output logic [2*WIDTH-1:0] Result,
    output logic               Busy,
    output logic               Valid,
    output logic               Error,
    output logic [1:0]         ErrCode
);

    seq_state_e         state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               add_sub_q, add_sub_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    err_e               err_q, err_d;

    logic tmo_clr;
    logic tmo_en;
    logic tmo_expired;

    calc_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (Clock),
        .rst_n   (Resetn),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // Any state change restarts the count, so each wait state gets its own full budget.
    assign tmo_clr = (state_d != state_q);
    assign tmo_en  = is_wait_state(state_q);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        add_sub_d = add_sub_q;
        result_d  = result_q;
        err_d     = err_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (Go) begin
                    state_d   = S_LATCH;
                    op_d      = op_e'(Op);
                    opa_d     = A;
                    opb_d     = B;
                    add_sub_d = Op[0];
                    err_d     = ERR_NONE;
                end
            end
            S_LATCH: begin
                unique case (op_q)
                    OP_ADD, OP_SUB: state_d = S_ADDS;
                    OP_MUL:         state_d = S_MSYNC;
                    OP_DIV: begin
                        if (opb_q == '0) begin
                            state_d  = S_ERR;
                            err_d    = ERR_DIV0;
                            result_d = '0;
                        end else begin
                            state_d = S_DSYNC;
                        end
                    end
                endcase
            end
            S_ADDS: begin
                result_d = {{(WIDTH-1){SumIn[WIDTH]}}, SumIn};
                state_d  = S_DONE;
            end
            // Exit conditions are tested before the timeout so a same-cycle Done still wins.
            S_MSYNC: begin
                if (MulDone) begin
                    state_d = S_MSTART;
                end else if (tmo_expired) begin
                    state_d  = S_ERR;
                    err_d    = ERR_TMO;
                    result_d = '0;
                end
            end
            S_MSTART: state_d = S_MWLO;
            S_MWLO: begin
                if (!MulDone) begin
                    state_d = S_MWHI;
                end else if (tmo_expired) begin
                    state_d  = S_ERR;
                    err_d    = ERR_TMO;
                    result_d = '0;
                end
            end
            S_MWHI: begin
                if (MulDone) begin
                    state_d  = S_DONE;
                    result_d = ProdIn;
                end else if (tmo_expired) begin
                    state_d  = S_ERR;
                    err_d    = ERR_TMO;
                    result_d = '0;
                end
            end
            S_DSYNC: begin
                if (DivDone) begin
                    state_d = S_DSTART;
                end else if (tmo_expired) begin
                    state_d  = S_ERR;
                    err_d    = ERR_TMO;
                    result_d = '0;
                end
            end
            S_DSTART: state_d = S_DWLO;
            S_DWLO: begin
                if (!DivDone) begin
                    state_d = S_DWHI;
                end else if (tmo_expired) begin
                    state_d  = S_ERR;
                    err_d    = ERR_TMO;
                    result_d = '0;
                end
            end
            S_DWHI: begin
                if (DivDone) begin
                    state_d  = S_DONE;
                    result_d = {RemIn, QuotIn};
                end else if (tmo_expired) begin
                    state_d  = S_ERR;
                    err_d    = ERR_TMO;
                    result_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ADD;
            opa_q     <= '0;
            opb_q     <= '0;
            add_sub_q <= 1'b0;
            result_q  <= '0;
            err_q     <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            add_sub_q <= add_sub_d;
            result_q  <= result_d;
            err_q     <= err_d;
        end
    end

    assign OpA      = opa_q;
    assign OpB      = opb_q;
    assign AddSub   = add_sub_q;
    assign Result   = result_q;
    assign ErrCode  = err_q;
    assign MulStart = (state_q == S_MSTART);
    assign DivStart = (state_q == S_DSTART);
    assign Valid    = (state_q == S_DONE);
    assign Error    = (state_q == S_ERR);
    assign Busy     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed self-checking bench for calc_op_sequencer with behavioural adder, multiplier and divider.
module tb_calc_op_sequencer;

    localparam int W       = 8;
    localparam int TMO     = 64;
    localparam int MUL_LAT = 10;
    localparam int DIV_LAT = 40;

    logic         Clock  = 1'b0;
    logic         Resetn = 1'b1;
    logic         Go     = 1'b0;
    logic [1:0]   Op     = 2'b00;
    logic [W-1:0] A      = '0;
    logic [W-1:0] B      = '0;

    logic [W-1:0]   OpA, OpB;
    logic           AddSub;
    logic [W:0]     SumIn;
    logic           MulStart, MulDone;
    logic [2*W-1:0] ProdIn;
    logic           DivStart, DivDone;
    logic [W-1:0]   QuotIn, RemIn;
    logic [2*W-1:0] Result;
    logic           Busy, Valid, Error;
    logic [1:0]     ErrCode;

    int tests  = 0;
    int failed = 0;

    calc_op_sequencer #(
        .WIDTH   (W),
        .TIMEOUT (TMO)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Go       (Go),
        .Op       (Op),
        .A        (A),
        .B        (B),
        .OpA      (OpA),
        .OpB      (OpB),
        .AddSub   (AddSub),
        .SumIn    (SumIn),
        .MulStart (MulStart),
        .MulDone  (MulDone),
        .ProdIn   (ProdIn),
        .DivStart (DivStart),
        .DivDone  (DivDone),
        .QuotIn   (QuotIn),
        .RemIn    (RemIn),
        .Result   (Result),
        .Busy     (Busy),
        .Valid    (Valid),
        .Error    (Error),
        .ErrCode  (ErrCode)
    );

    always #5 Clock = ~Clock;

    assign SumIn = AddSub ? ({1'b0, OpA} - {1'b0, OpB}) : ({1'b0, OpA} + {1'b0, OpB});

    // Unit models: Done drops the cycle after Start and rises again after the latency.
    logic           mul_busy = 1'b0, mul_stuck = 1'b0, div_busy = 1'b0;
    int             mul_cnt = 0, div_cnt = 0;
    logic [2*W-1:0] prod_r = '0;
    logic [W-1:0]   quot_r = '0, rem_r = '0;
    int             mul_starts = 0, div_starts = 0, bad_starts = 0;

    always @(posedge Clock) begin
        if (MulStart) mul_starts++;
        if (DivStart) div_starts++;
        if (DivStart && !DivDone) bad_starts++;
        if (MulStart && !mul_busy) begin
            mul_busy <= 1'b1;
            mul_cnt  <= MUL_LAT;
            prod_r   <= 16'(OpA) * 16'(OpB);
        end else if (mul_busy) begin
            if (mul_cnt <= 1) mul_busy <= 1'b0;
            mul_cnt <= mul_cnt - 1;
        end
        if (DivStart && !div_busy) begin
            div_busy <= 1'b1;
            div_cnt  <= DIV_LAT;
            quot_r   <= (OpB != 0) ? OpA / OpB : '1;
            rem_r    <= (OpB != 0) ? OpA % OpB : OpA;
        end else if (div_busy) begin
            if (div_cnt <= 1) div_busy <= 1'b0;
            div_cnt <= div_cnt - 1;
        end
    end

    assign MulDone = !mul_busy && !mul_stuck;
    assign ProdIn  = prod_r;
    assign DivDone = !div_busy;
    assign QuotIn  = quot_r;
    assign RemIn   = rem_r;

    // Presents one Go pulse; returns 1ns after the accepting edge.
    task automatic go(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Op = op; A = a; B = b; Go = 1'b1;
        @(posedge Clock); #1;
        Go = 1'b0;
    endtask

    task automatic wait_end(input int max_cycles, output bit ok);
        int n = 0;
        while (!(Valid || Error) && n < max_cycles) begin
            @(posedge Clock); #1;
            n++;
        end
        ok = Valid || Error;
    endtask

    task automatic test_reset;
        #2 Resetn = 1'b0;
        #1;
        tests++;
        if ({Result, OpA, OpB, AddSub, MulStart, DivStart, Busy, Valid, Error, ErrCode} !== '0) begin
            failed++;
            $display("FAIL reset_outputs got R=%h A=%h B=%h as=%b ms=%b ds=%b bsy=%b v=%b e=%b ec=%b exp all 0",
                     Result, OpA, OpB, AddSub, MulStart, DivStart, Busy, Valid, Error, ErrCode);
        end
        repeat (2) @(posedge Clock);
        @(negedge Clock) Resetn = 1'b1;
        @(posedge Clock); #1;
        tests++;
        if ({Busy, Valid, Error} !== 3'b000) begin
            failed++;
            $display("FAIL reset_idle got bsy/v/e=%b exp 000", {Busy, Valid, Error});
        end
    endtask

    task automatic test_add;
        int m0 = mul_starts, d0 = div_starts;
        go(2'b00, 8'h7F, 8'h01);
        tests++;
        if ({Busy, Valid} !== 2'b10) begin
            failed++;
            $display("FAIL add_accept got bsy/v=%b exp 10", {Busy, Valid});
        end
        A = 8'hAA; B = 8'h55; Op = 2'b11;
        @(posedge Clock); #1;
        tests++;
        if (Valid !== 1'b0) begin
            failed++;
            $display("FAIL add_early_valid got %b exp 0", Valid);
        end
        @(posedge Clock); #1;
        tests++;
        if ({Valid, Busy, Result} !== {2'b10, 16'h0080}) begin
            failed++;
            $display("FAIL add_result got v=%b bsy=%b R=%h exp v=1 bsy=0 R=0080", Valid, Busy, Result);
        end
        tests++;
        if ({OpA, OpB} !== {8'h7F, 8'h01}) begin
            failed++;
            $display("FAIL add_operand_hold got %h/%h exp 7f/01", OpA, OpB);
        end
        tests++;
        if ((mul_starts != m0) || (div_starts != d0)) begin
            failed++;
            $display("FAIL add_no_start got mul=%0d div=%0d exp mul=%0d div=%0d", mul_starts, div_starts, m0, d0);
        end
    endtask

    task automatic test_sub;
        go(2'b01, 8'h03, 8'h05);
        @(posedge Clock); #1;
        tests++;
        if (AddSub !== 1'b1) begin
            failed++;
            $display("FAIL sub_addsub got %b exp 1", AddSub);
        end
        @(posedge Clock); #1;
        tests++;
        if ({Valid, Result} !== {1'b1, 16'hFFFE}) begin
            failed++;
            $display("FAIL sub_result got v=%b R=%h exp v=1 R=fffe", Valid, Result);
        end
    endtask

    task automatic test_mul;
        bit ok;
        int m0 = mul_starts;
        go(2'b10, 8'd12, 8'd13);
        tests++;
        if (Result !== 16'hFFFE) begin
            failed++;
            $display("FAIL mul_result_hold got %h exp fffe", Result);
        end
        Op = 2'b00; A = 8'h01; B = 8'h01; Go = 1'b1;
        @(posedge Clock); #1;
        Go = 1'b0;
        wait_end(200, ok);
        tests++;
        if (!ok || {Valid, Error, Result} !== {2'b10, 16'h009C}) begin
            failed++;
            $display("FAIL mul_result got ok=%b v=%b e=%b R=%h exp ok=1 v=1 e=0 R=009c", ok, Valid, Error, Result);
        end
        tests++;
        if (mul_starts != m0 + 1) begin
            failed++;
            $display("FAIL mul_start_count got %0d exp %0d", mul_starts, m0 + 1);
        end
    endtask

    task automatic test_div;
        bit ok;
        int d0 = div_starts;
        go(2'b11, 8'd100, 8'd7);
        wait_end(200, ok);
        tests++;
        if (!ok || {Valid, Busy, Result} !== {2'b10, 8'd2, 8'd14}) begin
            failed++;
            $display("FAIL div_result got ok=%b v=%b bsy=%b R=%h exp ok=1 v=1 bsy=0 R=020e", ok, Valid, Busy, Result);
        end
        tests++;
        if ((div_starts != d0 + 1) || (bad_starts != 0)) begin
            failed++;
            $display("FAIL div_start_count got %0d bad=%0d exp %0d bad=0", div_starts, bad_starts, d0 + 1);
        end
    endtask

    task automatic test_div0;
        int d0 = div_starts;
        go(2'b11, 8'd5, 8'd0);
        @(posedge Clock); #1;
        tests++;
        if ({Error, ErrCode, Valid, Busy, Result} !== {1'b1, 2'b01, 2'b00, 16'h0000}) begin
            failed++;
            $display("FAIL div0_err got e=%b ec=%b v=%b bsy=%b R=%h exp e=1 ec=01 v=0 bsy=0 R=0000",
                     Error, ErrCode, Valid, Busy, Result);
        end
        repeat (3) @(posedge Clock); #1;
        tests++;
        if (div_starts != d0) begin
            failed++;
            $display("FAIL div0_no_start got %0d exp %0d", div_starts, d0);
        end
    endtask

    task automatic test_timeout;
        int m0 = mul_starts;
        mul_stuck = 1'b1;
        go(2'b10, 8'd3, 8'd4);
        repeat (TMO) @(posedge Clock); #1;
        tests++;
        if ({Error, Busy} !== 2'b01) begin
            failed++;
            $display("FAIL tmo_early got e/bsy=%b exp 01", {Error, Busy});
        end
        @(posedge Clock); #1;
        tests++;
        if ({Error, ErrCode, Busy, Result} !== {1'b1, 2'b10, 1'b0, 16'h0000}) begin
            failed++;
            $display("FAIL tmo_err got e=%b ec=%b bsy=%b R=%h exp e=1 ec=10 bsy=0 R=0000", Error, ErrCode, Busy, Result);
        end
        tests++;
        if (mul_starts != m0) begin
            failed++;
            $display("FAIL tmo_no_start got %0d exp %0d", mul_starts, m0);
        end
        mul_stuck = 1'b0;
    endtask

    task automatic test_back_to_back;
        Op = 2'b00; A = 8'd1; B = 8'd2; Go = 1'b1;
        @(posedge Clock); #1;
        tests++;
        if ({Busy, Error, ErrCode} !== 4'b1000) begin
            failed++;
            $display("FAIL b2b_clear_err got bsy=%b e=%b ec=%b exp bsy=1 e=0 ec=00", Busy, Error, ErrCode);
        end
        repeat (2) @(posedge Clock); #1;
        tests++;
        if ({Valid, Result} !== {1'b1, 16'h0003}) begin
            failed++;
            $display("FAIL b2b_first got v=%b R=%h exp v=1 R=0003", Valid, Result);
        end
        A = 8'd10; B = 8'd20;
        @(posedge Clock); #1;
        Go = 1'b0;
        tests++;
        if ({Busy, Valid} !== 2'b10) begin
            failed++;
            $display("FAIL b2b_relatch got bsy/v=%b exp 10", {Busy, Valid});
        end
        repeat (2) @(posedge Clock); #1;
        tests++;
        if ({Valid, Result} !== {1'b1, 16'h001E}) begin
            failed++;
            $display("FAIL b2b_second got v=%b R=%h exp v=1 R=001e", Valid, Result);
        end
    endtask

    task automatic test_reset_mid_div;
        bit ok;
        int d0 = div_starts;
        go(2'b11, 8'd200, 8'd9);
        for (int i = 0; i < 20 && div_starts == d0; i++) @(posedge Clock);
        #1;
        tests++;
        if (div_starts != d0 + 1) begin
            failed++;
            $display("FAIL rst_div_start got %0d exp %0d", div_starts, d0 + 1);
        end
        repeat (10) @(posedge Clock);
        #4 Resetn = 1'b0;
        #1;
        tests++;
        if ({Result, OpA, OpB, AddSub, MulStart, DivStart, Busy, Valid, Error, ErrCode} !== '0) begin
            failed++;
            $display("FAIL rst_async got R=%h A=%h B=%h as=%b ds=%b bsy=%b v=%b exp all 0",
                     Result, OpA, OpB, AddSub, DivStart, Busy, Valid);
        end
        @(negedge Clock) Resetn = 1'b1;
        @(posedge Clock); #1;
        d0 = div_starts;
        go(2'b11, 8'd50, 8'd6);
        repeat (5) @(posedge Clock); #1;
        tests++;
        if ({div_starts == d0, Busy, DivDone} !== 3'b110) begin
            failed++;
            $display("FAIL rst_sync_wait got nostart=%b bsy=%b dd=%b exp 1 1 0", div_starts == d0, Busy, DivDone);
        end
        wait_end(200, ok);
        tests++;
        if (!ok || {Valid, Result} !== {1'b1, 8'd2, 8'd8}) begin
            failed++;
            $display("FAIL rst_div_result got ok=%b v=%b R=%h exp ok=1 v=1 R=0208", ok, Valid, Result);
        end
        tests++;
        if ((div_starts != d0 + 1) || (bad_starts != 0)) begin
            failed++;
            $display("FAIL rst_div_pulse got %0d bad=%0d exp %0d bad=0", div_starts, bad_starts, d0 + 1);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_mul;
        test_div;
        test_div0;
        test_timeout;
        test_back_to_back;
        test_reset_mid_div;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
